load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-side initiator for the RV32I datapath. It accepts one load or store request at a time from the execute stage and drives the word-organised data memory's read/write-enable, address and write-data inputs. On loads, it extracts and sign- or zero-extends the addressed byte, halfword or word. Sub-word stores are done as read-modify-write sequences, because the memory only writes whole words.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits and the memory is word-addressed.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present; taken only while req_ready=1
- req_ready  out  1  unit idle and able to accept
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes illegal
- req_addr  in  32  byte address
- req_store_data  in  32  store source (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_load_data  out  32  extended load result; 0 for stores and errors
- resp_error  out  1  misaligned address or illegal funct3
- mem_read_enable  out  1  to the data memory
- mem_write_enable  out  1  to the data memory
- mem_address  out  32  word index = {2'b00, addr[31:2]}
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read data; valid in the same cycle as mem_read_enable

## Operation
- Acceptance: on req_valid & req_ready, latch op, funct3, addr and store data. States are IDLE, ACCESS, WRITE and RESP.
- IDLE: req_ready=1 and all mem_* outputs are 0.
  - An accepted request with an illegal funct3 goes to RESP with the error flag set.
  - A misaligned request also goes to RESP with the error flag set. Misaligned means H with addr[0]=1, or W with addr[1:0]≠0.
  - Erroring requests make no memory access.
  - Any other accepted request goes to ACCESS.
- ACCESS (loads, SB, SH):
  - mem_read_enable=1 and mem_address=word index.
  - mem_read_data is captured at the clock edge.
  - A load goes to RESP with its result registered. An SB or SH goes to WRITE with the merged word registered.
- ACCESS (SW): mem_write_enable=1, mem_write_data=store data, mem_read_enable=0; then go to RESP.
- Load extraction: byte lane = addr[1:0] (lane 0 = bits 7:0); halfword = addr[1] (0 → bits 15:0).
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through unchanged.
- Sub-word merge:
  - SB replaces byte lane addr[1:0] with store_data[7:0].
  - SH replaces halfword addr[1] with store_data[15:0].
  - All other bits keep the value read.
- WRITE: mem_write_enable=1, mem_write_data=merged word, same mem_address; then go to RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_load_data and resp_error; req_ready=0; then go to IDLE.
- mem_read_enable and mem_write_enable are never high in the same cycle.
- mem_address holds the latched word index throughout ACCESS and WRITE, and is 0 in IDLE and RESP.

## Timing
- Reset (asynchronous): state=IDLE, all latched registers 0.
  - Reset outputs: req_ready=1, resp_valid=0, resp_load_data=0, resp_error=0, mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_write_data=0.
- Reset during ACCESS or WRITE aborts the operation immediately. The write enable drops asynchronously, and no response is issued.
- Latency from the acceptance edge (cycle 0) to resp_valid:
  - load: cycle 2
  - SW: cycle 2
  - SB/SH: cycle 3
  - error: cycle 1
- Back-to-back: req_ready rises in the cycle after RESP. A new request is accepted no sooner than one cycle after resp_valid.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it is accepted.
- Request inputs are sampled only at acceptance; changes after acceptance have no effect.

## Test plan
- Reset state: assert reset mid-cycle → all outputs immediately match the reset values listed above; req_ready=1 after release.
- Aligned word round trip: SW addr 0x0000_0010 data 0xDEADBEEF, with memory[4] checked after the write.
  - Required: mem_write_enable high for one cycle with mem_address=4; resp_valid at cycle 2.
  - Then LW 0x10 → resp_load_data=0xDEADBEEF at cycle 2.
- Sub-word store: memory[1]=0x11223344, then SB addr 0x6 data 0xAB.
  - Required: read in cycle 1, write of 0x11AB3344 in cycle 2, resp_valid at cycle 3.
  - Then SH addr 0x4 data 0xBEEF → memory[1]=0x11ABBEEF.
- Extension: memory[0]=0x80FF7F01.
  - LB 0x2 → 0xFFFFFFFF.
  - LBU 0x3 → 0x00000080.
  - LH 0x2 → 0xFFFF80FF.
  - LHU 0x0 → 0x00007F01.
  - LB 0x1 → 0x0000007F.
- Errors:
  - LW 0x2, SH 0x1 and funct3=011 → resp_error=1 at cycle 1, resp_load_data=0, no mem enables.
  - A following LW 0x0 completes normally.
- Reset mid-RMW: reset asserted during the WRITE of SB 0x5 → mem_write_enable drops immediately, no resp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator for a word-organised data memory
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [31:0] resp_load_data,
  output logic        resp_error,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] result_q, result_d;
  logic        error_q, error_d;

  logic        illegal, misaligned, is_sw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext, merged, word_index;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      result_q   <= 32'h0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      result_q   <= result_d;
      error_q    <= error_d;
    end
  end

  // LBU/LHU encodings have no store counterpart, so they are illegal for stores
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_is_store;
      default:                illegal = 1'b1;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    byte_sel = mem_read_data[7:0];
    merged   = mem_read_data;
    case (addr_q[1:0])
      2'b00: begin byte_sel = mem_read_data[7:0];   merged[7:0]   = data_q[7:0]; end
      2'b01: begin byte_sel = mem_read_data[15:8];  merged[15:8]  = data_q[7:0]; end
      2'b10: begin byte_sel = mem_read_data[23:16]; merged[23:16] = data_q[7:0]; end
      default: begin byte_sel = mem_read_data[31:24]; merged[31:24] = data_q[7:0]; end
    endcase
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    if (funct3_q[0]) begin
      merged = mem_read_data;
      if (addr_q[1]) merged[31:16] = data_q[15:0];
      else           merged[15:0]  = data_q[15:0];
    end
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_read_data;
    endcase
  end

  assign is_sw      = is_store_q && (funct3_q == 3'b010);
  assign word_index = {2'b00, addr_q[31:2]};

  always_comb begin
    state_d          = state_q;
    is_store_d       = is_store_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    data_d           = data_q;
    result_d         = result_q;
    error_d          = error_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_load_data   = 32'h0;
    resp_error       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = 32'h0;
    mem_write_data   = 32'h0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          data_d     = req_store_data;
          result_d   = 32'h0;
          error_d    = illegal || misaligned;
          state_d    = (illegal || misaligned) ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_address = word_index;
        if (is_sw) begin
          mem_write_enable = 1'b1;
          mem_write_data   = data_q;
          result_d         = 32'h0;
          state_d          = S_RESP;
        end else begin
          mem_read_enable = 1'b1;
          result_d        = is_store_q ? merged : load_ext;
          state_d         = is_store_q ? S_WRITE : S_RESP;
        end
      end
      S_WRITE: begin
        mem_address      = word_index;
        mem_write_enable = 1'b1;
        mem_write_data   = result_q;
        result_d         = 32'h0;
        state_d          = S_RESP;
      end
      default: begin
        resp_valid     = 1'b1;
        resp_load_data = result_q;
        resp_error     = error_q;
        state_d        = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_store_data = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_load_data;
  logic        resp_error;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:15];
  int vectors = 0;
  int fails = 0;

  load_store_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_load_data(resp_load_data), .resp_error(resp_error),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_write_enable) mem[mem_address[3:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[3:0]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                        input int exp_reads, input int exp_writes, input logic [31:0] exp_wdata);
    int lat = 0, resp_cnt = 0, reads = 0, writes = 0, wcyc = 0, addr_bad = 0, both = 0;
    logic [31:0] got_data = 32'h0, wdata = 32'h0;
    logic got_err = 1'b0;
    @(negedge clock);
    check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    req_is_store = st; req_funct3 = f3; req_addr = addr; req_store_data = data;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_funct3 = 3'b011; req_addr = ~addr; req_store_data = 32'h5a5a5a5a;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      if (resp_valid) begin
        resp_cnt++;
        if (lat == 0) lat = cyc;
        got_data = resp_load_data;
        got_err  = resp_error;
      end
      if (mem_read_enable) reads++;
      if (mem_write_enable) begin
        writes++;
        wdata = mem_write_data;
        if (wcyc == 0) wcyc = cyc;
      end
      if ((mem_read_enable || mem_write_enable) && (mem_address !== {2'b00, addr[31:2]})) addr_bad++;
      if (mem_read_enable && mem_write_enable) both++;
    end
    check({tag, " latency"},   lat, exp_lat);
    check({tag, " resp_cnt"},  resp_cnt, 1);
    check({tag, " load_data"}, got_data, exp_data);
    check({tag, " error"},     {31'h0, got_err}, {31'h0, exp_err});
    check({tag, " reads"},     reads, exp_reads);
    check({tag, " writes"},    writes, exp_writes);
    check({tag, " wdata"},     wdata, exp_wdata);
    check({tag, " wcycle"},    wcyc, (exp_writes != 0) ? exp_lat - 1 : 0);
    check({tag, " addr"},      addr_bad, 0);
    check({tag, " rw_excl"},   both, 0);
  endtask

  initial begin
    // Power-up reset, then reset asserted mid-cycle during a load's ACCESS
    #12 reset = 1'b0;
    @(negedge clock);
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("pre-reset read_en", {31'h0, mem_read_enable}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst req_ready",   {31'h0, req_ready}, 32'h1);
    check("rst resp_valid",  {31'h0, resp_valid}, 32'h0);
    check("rst load_data",   resp_load_data, 32'h0);
    check("rst resp_error",  {31'h0, resp_error}, 32'h0);
    check("rst read_en",     {31'h0, mem_read_enable}, 32'h0);
    check("rst write_en",    {31'h0, mem_write_enable}, 32'h0);
    check("rst mem_address", mem_address, 32'h0);
    check("rst write_data",  mem_write_data, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post-rst ready", {31'h0, req_ready}, 32'h1);

    do_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1, 32'hDEADBEEF);
    check("mem4", mem[4], 32'hDEADBEEF);
    do_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0, 32'h0);

    do_req("sw_4",  1'b1, 3'b010, 32'h4, 32'h11223344, 2, 32'h0, 1'b0, 0, 1, 32'h11223344);
    do_req("sb_6",  1'b1, 3'b000, 32'h6, 32'h000000AB, 3, 32'h0, 1'b0, 1, 1, 32'h11AB3344);
    check("mem1 sb", mem[1], 32'h11AB3344);
    do_req("sh_4",  1'b1, 3'b001, 32'h4, 32'h0000BEEF, 3, 32'h0, 1'b0, 1, 1, 32'h11ABBEEF);
    check("mem1 sh", mem[1], 32'h11ABBEEF);

    do_req("sw_0",  1'b1, 3'b010, 32'h0, 32'h80FF7F01, 2, 32'h0, 1'b0, 0, 1, 32'h80FF7F01);
    do_req("lb_2",  1'b0, 3'b000, 32'h2, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 1, 0, 32'h0);
    do_req("lbu_3", 1'b0, 3'b100, 32'h3, 32'h0, 2, 32'h00000080, 1'b0, 1, 0, 32'h0);
    do_req("lh_2",  1'b0, 3'b001, 32'h2, 32'h0, 2, 32'hFFFF80FF, 1'b0, 1, 0, 32'h0);
    do_req("lhu_0", 1'b0, 3'b101, 32'h0, 32'h0, 2, 32'h00007F01, 1'b0, 1, 0, 32'h0);
    do_req("lb_1",  1'b0, 3'b000, 32'h1, 32'h0, 2, 32'h0000007F, 1'b0, 1, 0, 32'h0);

    do_req("lw_2 err",  1'b0, 3'b010, 32'h2, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    do_req("sh_1 err",  1'b1, 3'b001, 32'h1, 32'h1234, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    do_req("f3_011 err", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    do_req("lw_0",  1'b0, 3'b010, 32'h0, 32'h0, 2, 32'h80FF7F01, 1'b0, 1, 0, 32'h0);

    // Reset while the SB read-modify-write is in its WRITE cycle
    @(negedge clock);
    req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h5; req_store_data = 32'h77;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("rmw read_en c1", {31'h0, mem_read_enable}, 32'h1);
    @(negedge clock);
    check("rmw write_en c2", {31'h0, mem_write_enable}, 32'h1);
    check("rmw wdata c2", mem_write_data, 32'h11AB77EF);
    #2 reset = 1'b1;
    #1;
    check("rmw abort write_en", {31'h0, mem_write_enable}, 32'h0);
    check("rmw abort address", mem_address, 32'h0);
    check("rmw abort resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    begin
      int resp_seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clock);
        if (resp_valid) resp_seen++;
      end
      check("rmw no resp", resp_seen, 0);
    end
    check("rmw ready", {31'h0, req_ready}, 32'h1);
    check("rmw mem1 kept", mem[1], 32'h11ABBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
